tdm_chan_sched: RTL and testbench

Round-robin time-division scheduler that sits directly upstream of the 4:1 byte mux / 1:4 demux pair. It arbitrates among four requesting channels and drives the shared 2-bit select `s` to both mux and demux. It holds `s` stable for a burst of beats and runs a valid/ready handshake with the consumer of the mux output `y`. Per-channel acknowledges are returned to the sources.

---
 rtl/tdm_pkg.sv | 35 +++
 rtl/tdm_rr_arb.sv | 25 ++
 rtl/tdm_chan_sched.sv | 104 ++++++++++
 tb/tb_tdm_chan_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the TDM channel scheduler.
//   - tdm_state_e : scheduler FSM states (IDLE, GRANT)
//   - NCH, SELW   : channel count and select width
//   - rr_pick()   : round-robin winner select; scans upward from ptr with wrap
// Build option: TDM_ROUND_ROBIN_EN (see tdm_chan_sched.sv).
package tdm_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } tdm_state_e;

  // First set request at or above ptr wins, wrapping naturally in SELW bits.
  // Returns 0 when no request is set; callers only use it with req != 0.
  function automatic logic [SELW-1:0] rr_pick(input logic [NCH-1:0]  req,
                                              input logic [SELW-1:0] ptr);
    logic [SELW-1:0] idx;
    logic [SELW-1:0] win;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = ptr + SELW'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/tdm_rr_arb.sv
// tdm_rr_arb: purely combinational winner select for the TDM scheduler.
// Ports:
//   i_req    [NCH-1:0]  channel requests
//   i_ptr    [SELW-1:0] round-robin start point (only with TDM_ROUND_ROBIN_EN)
//   o_winner [SELW-1:0] selected channel
// Build option: TDM_ROUND_ROBIN_EN defined -> round-robin from i_ptr;
// undefined -> fixed priority, lowest index wins, no pointer input.
module tdm_rr_arb
  import tdm_pkg::*;
(
  input  logic [NCH-1:0]  i_req,
`ifdef TDM_ROUND_ROBIN_EN
  input  logic [SELW-1:0] i_ptr,
`endif
  output logic [SELW-1:0] o_winner
);

`ifdef TDM_ROUND_ROBIN_EN
  assign o_winner = rr_pick(i_req, i_ptr);
`else
  // A scan starting at channel 0 is exactly lowest-index-first priority.
  assign o_winner = rr_pick(i_req, '0);
`endif

endmodule

// File: rtl/tdm_chan_sched.sv
// tdm_chan_sched: round-robin time-division scheduler driving the shared
// select of a 4:1 byte mux / 1:4 demux pair, with burst hold and a
// valid/ready handshake towards the consumer of the mux output.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   req[3:0]   per-channel "byte valid on mux input i"
//   s[1:0]     registered select to mux and demux
//   y_valid    mux output carries a valid beat (combinational)
//   y_ready    consumer accepts the beat
//   ack[3:0]   one-hot: channel's beat consumed this cycle (combinational)
//   busy       registered: a grant is active
//   dbg_state  current FSM state, for observation
// Handshake: a beat transfers in a cycle where y_valid && y_ready. y_valid
// follows req[s] during GRANT; while y_ready is low everything holds.
// Build option: TDM_ROUND_ROBIN_EN selects round-robin arbitration; without
// it arbitration is fixed priority and the pointer register is not built.
module tdm_chan_sched
  import tdm_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CW        = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  output logic [SELW-1:0]   s,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [NCH-1:0]    ack,
  output logic              busy,
  output tdm_state_e        dbg_state
);

  tdm_state_e      r_state;
  logic [SELW-1:0] r_s;
  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [SELW-1:0] w_winner;
  logic            w_fire;
  logic            w_last;

`ifdef TDM_ROUND_ROBIN_EN
  logic [SELW-1:0] r_ptr;
`endif

  tdm_rr_arb u_arb (
    .i_req    (req),
`ifdef TDM_ROUND_ROBIN_EN
    .i_ptr    (r_ptr),
`endif
    .o_winner (w_winner)
  );

  assign y_valid   = (r_state == ST_GRANT) && req[r_s];
  assign w_fire    = y_valid && y_ready;
  // Count holds beats already taken; this beat completes the burst.
  assign w_last    = (r_cnt == CW'(BURST_LEN - 1));
  assign s         = r_s;
  assign busy      = r_busy;
  assign dbg_state = r_state;

  // A beat coinciding with reset is dropped, so it must not be acknowledged.
  always_comb begin
    ack = '0;
    if (w_fire && !rst) ack[r_s] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
`ifdef TDM_ROUND_ROBIN_EN
      r_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_s     <= w_winner;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Withdrawal forfeits the remainder of the burst.
          if (!req[r_s] || (w_fire && w_last)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`ifdef TDM_ROUND_ROBIN_EN
            r_ptr   <= r_s + SELW'(1);
`endif
          end else if (w_fire) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_chan_sched.sv
// tb_tdm_chan_sched: directed self-checking bench for tdm_chan_sched
// (BURST_LEN = 4). Inputs change 1 time unit after the rising edge and
// outputs are checked 1 time unit later, well away from the next edge.
module tb_tdm_chan_sched;
  import tdm_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] s;
  logic       y_valid;
  logic       y_ready;
  logic [3:0] ack;
  logic       busy;
  tdm_state_e dbg_state;

  int n_tests;
  int n_fail;

  tdm_chan_sched #(.BURST_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .s         (s),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .ack       (ack),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs may then be driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset for two edges, check reset values, then release reset in cycle 0.
  task automatic do_reset(input logic [3:0] r, input logic yr);
    rst = 1'b1; req = 4'b0000; y_ready = 1'b0;
    repeat (2) cyc();
    req = r; y_ready = yr;
    settle();
    chk("rst_s",       8'(s), 8'd0);
    chk("rst_busy",    8'(busy), 8'd0);
    chk("rst_yvalid",  8'(y_valid), 8'd0);
    chk("rst_ack",     8'(ack), 8'd0);
    chk("rst_state",   8'(dbg_state), 8'(ST_IDLE));
    rst = 1'b0;
  endtask

  // One granted beat at full rate: s, busy and the one-hot ack.
  task automatic beat(input string tag, input logic [1:0] exp_s);
    cyc();
    settle();
    chk({tag, "_s"},    8'(s), 8'(exp_s));
    chk({tag, "_busy"}, 8'(busy), 8'd1);
    chk({tag, "_ack"},  8'(ack), 8'(4'b0001 << exp_s));
  endtask

  task automatic bubble(input string tag);
    cyc();
    settle();
    chk({tag, "_busy"},   8'(busy), 8'd0);
    chk({tag, "_yvalid"}, 8'(y_valid), 8'd0);
    chk({tag, "_ack"},    8'(ack), 8'd0);
    chk({tag, "_state"},  8'(dbg_state), 8'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] exp_s;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; req = '0; y_ready = 1'b0;

    // 1: single channel, full-rate burst of 4 then release
    do_reset(4'b0001, 1'b1);
    chk("t1_c0_yvalid", 8'(y_valid), 8'd0);
    for (int b = 0; b < 4; b++) beat("t1_beat", 2'd0);
    req = 4'b0000;
    bubble("t1_c5");

    // 2/3: all channels requesting; order depends on arbitration build
    do_reset(4'b1111, 1'b1);
    for (int g = 0; g < 5; g++) begin
`ifdef TDM_ROUND_ROBIN_EN
      exp_s = 2'(g);
`else
      exp_s = 2'd0;
`endif
      for (int b = 0; b < 4; b++) beat("t2_beat", exp_s);
      bubble("t2_bubble");
    end

    // 4: backpressure for 3 cycles after beat 2
    do_reset(4'b0001, 1'b1);
    beat("t4_b1", 2'd0);
    beat("t4_b2", 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      y_ready = 1'b0;
      settle();
      chk("t4_hold_ack",    8'(ack), 8'd0);
      chk("t4_hold_yvalid", 8'(y_valid), 8'd1);
      chk("t4_hold_s",      8'(s), 8'd0);
      chk("t4_hold_busy",   8'(busy), 8'd1);
    end
    cyc();
    y_ready = 1'b1;
    settle();
    chk("t4_b3_ack", 8'(ack), 8'b0001);
    beat("t4_b4", 2'd0);
    req = 4'b0000;
    bubble("t4_release");

    // 5: channel 0 withdraws after 2 beats while channel 2 requests
    do_reset(4'b0001, 1'b1);
    beat("t5_b1", 2'd0);
    beat("t5_b2", 2'd0);
    cyc();
    req = 4'b0100;
    settle();
    chk("t5_wd_yvalid", 8'(y_valid), 8'd0);
    chk("t5_wd_ack",    8'(ack), 8'd0);
    chk("t5_wd_busy",   8'(busy), 8'd1);
    bubble("t5_bubble");
    for (int b = 0; b < 4; b++) beat("t5_ch2", 2'd2);
    bubble("t5_end");

    // 6: reset coincident with a firing beat in the second grant
    do_reset(4'b1111, 1'b1);
    for (int b = 0; b < 4; b++) beat("t6_g0", 2'd0);
    bubble("t6_bubble");
`ifdef TDM_ROUND_ROBIN_EN
    exp_s = 2'd1;
`else
    exp_s = 2'd0;
`endif
    beat("t6_g1_b1", exp_s);
    beat("t6_g1_b2", exp_s);
    cyc();
    rst = 1'b1;
    settle();
    chk("t6_rst_yvalid", 8'(y_valid), 8'd1);
    chk("t6_rst_ack",    8'(ack), 8'd0);
    cyc();
    rst = 1'b0;
    settle();
    chk("t6_post_s",      8'(s), 8'd0);
    chk("t6_post_busy",   8'(busy), 8'd0);
    chk("t6_post_yvalid", 8'(y_valid), 8'd0);
    chk("t6_post_ack",    8'(ack), 8'd0);
    beat("t6_regrant", 2'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
